// File: rtl/store_buffer_if.sv
// Store/load/DataMem bundle for store_buffer.
//  master : pipeline + DataMem side (drives st_*, ld_req/ld_addr, mem_read_data)
//  slave  : store_buffer side (drives st_ready, ld_data/ld_fwd, mem_* outputs)
interface store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [15:0] st_addr;
  logic [15:0] st_data;
  logic        ld_req;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;
  logic        ld_fwd;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [15:0] mem_read_data;

  modport master (
    output st_valid, st_addr, st_data, ld_req, ld_addr, mem_read_data,
    input  st_ready, ld_data, ld_fwd, mem_access_addr, mem_write_data,
           mem_write_en, mem_read
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_req, ld_addr, mem_read_data,
    output st_ready, ld_data, ld_fwd, mem_access_addr, mem_write_data,
           mem_write_en, mem_read
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer in front of DataMem.
// Stores queue in a circular FIFO and drain one per cycle whenever no load
// owns the DataMem address bus. Loads go straight to DataMem and pick up the
// youngest queued store whose low MATCH_W address bits match.
// Ports:
//  clk, rst_n   clock, async active-low reset
//  bus          store_buffer_if.slave (store handshake, load port, DataMem port)
//  count        entries held
//  empty        count == 0
module store_buffer #(
  parameter int DEPTH   = 4,
  parameter int MATCH_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  store_buffer_if.slave            bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } sb_entry_t;

  sb_entry_t     ent_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt_q;
  logic          push, drain;

  assign bus.st_ready = (cnt_q != FULL_CNT);
  assign empty        = (cnt_q == '0);
  assign count        = cnt_q;
  assign push         = bus.st_valid && bus.st_ready;
  // Loads own the single DataMem address bus; the drain waits.
  assign drain        = !bus.ld_req && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (drain) rd_ptr <= rd_ptr + 1'b1;
      case ({push, drain})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) ent_q[wr_ptr] <= '{addr: bus.st_addr, data: bus.st_data};
  end

  // Entries viewed in age order: slot 0 is the head (oldest).
  logic [DEPTH-1:0]       age_hit;
  logic [DEPTH-1:0][15:0] age_data;

  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    logic [PW-1:0] idx;
    assign idx         = rd_ptr + PW'(i);
    assign age_hit[i]  = ((PW+1)'(i) < cnt_q) &&
                         (ent_q[idx].addr[MATCH_W-1:0] == bus.ld_addr[MATCH_W-1:0]);
    assign age_data[i] = ent_q[idx].data;
  end

  logic        fwd_hit;
  logic [15:0] fwd_data;

  // Later (younger) slots override earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_hit[i]) begin
        fwd_hit  = 1'b1;
        fwd_data = age_data[i];
      end
    end
  end

  // DataMem port is driven only from registered state and the load port,
  // so st_* never reaches mem_* combinationally.
  always_comb begin
    bus.mem_access_addr = '0;
    bus.mem_write_data  = '0;
    bus.mem_write_en    = 1'b0;
    bus.mem_read        = 1'b0;
    bus.ld_data         = '0;
    bus.ld_fwd          = 1'b0;
    if (bus.ld_req) begin
      bus.mem_access_addr = bus.ld_addr;
      bus.mem_read        = 1'b1;
      bus.ld_fwd          = fwd_hit;
      bus.ld_data         = fwd_hit ? fwd_data : bus.mem_read_data;
    end else if (!empty) begin
      bus.mem_access_addr = ent_q[rd_ptr].addr;
      bus.mem_write_data  = ent_q[rd_ptr].data;
      bus.mem_write_en    = 1'b1;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] count;
  logic       empty;

  always #5 clk = ~clk;

  store_buffer_if sb_if();

  store_buffer #(.DEPTH(DEPTH), .MATCH_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sb_if.slave),
    .count (count),
    .empty (empty)
  );

  // DataMem model: 8 words decoded from addr[2:0], combinational read.
  logic [15:0] dmem [8] = '{default: 16'h0};
  assign sb_if.mem_read_data = dmem[sb_if.mem_access_addr[2:0]];

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  ent_t        sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        m_hit, m_acc;
  logic [15:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard/monitor: inputs change just after posedge, so everything is
  // stable at negedge. Stores are pushed when accepted, popped when drained.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_ready", 32'(sb_if.st_ready), 32'd1);
      chk("rst_we",    32'(sb_if.mem_write_en), 32'd0);
    end else begin
      chk("count", 32'(count), 32'(sb_q.size()));
      chk("empty", 32'(empty), 32'(sb_q.size() == 0));
      m_acc = (sb_q.size() != DEPTH);
      chk("st_ready", 32'(sb_if.st_ready), 32'(m_acc));
      if (sb_if.ld_req) begin
        m_hit  = 1'b0;
        m_data = dmem[sb_if.ld_addr[2:0]];
        foreach (sb_q[i])
          if (sb_q[i].a[2:0] == sb_if.ld_addr[2:0]) begin
            m_hit  = 1'b1;
            m_data = sb_q[i].d;
          end
        chk("ld_data",  32'(sb_if.ld_data), 32'(m_data));
        chk("ld_fwd",   32'(sb_if.ld_fwd), 32'(m_hit));
        chk("ld_read",  32'(sb_if.mem_read), 32'd1);
        chk("ld_we",    32'(sb_if.mem_write_en), 32'd0);
        chk("ld_addr",  32'(sb_if.mem_access_addr), 32'(sb_if.ld_addr));
      end else begin
        chk("idle_ld_data", 32'(sb_if.ld_data), 32'd0);
        chk("idle_ld_fwd",  32'(sb_if.ld_fwd), 32'd0);
        chk("idle_read",    32'(sb_if.mem_read), 32'd0);
        chk("drain_we",     32'(sb_if.mem_write_en), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
          chk("drain_addr", 32'(sb_if.mem_access_addr), 32'(sb_q[0].a));
          chk("drain_data", 32'(sb_if.mem_write_data), 32'(sb_q[0].d));
          dmem[sb_q[0].a[2:0]] = sb_q[0].d;
          void'(sb_q.pop_front());
        end
      end
      if (sb_if.st_valid && m_acc) sb_q.push_back('{a: sb_if.st_addr, d: sb_if.st_data});
    end
  end

  task automatic cyc(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                     input logic lr, input logic [15:0] la);
    @(posedge clk); #1;
    sb_if.st_valid = sv;
    sb_if.st_addr  = sa;
    sb_if.st_data  = sd;
    sb_if.ld_req   = lr;
    sb_if.ld_addr  = la;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_if.st_valid = 1'b0;
    sb_if.st_addr  = '0;
    sb_if.st_data  = '0;
    sb_if.ld_req   = 1'b0;
    sb_if.ld_addr  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: reset with 3 queued entries (held by a load) discards them.
    cyc(1'b1, 16'h4, 16'hA004, 1'b1, 16'h7);
    cyc(1'b1, 16'h5, 16'hA005, 1'b1, 16'h7);
    cyc(1'b1, 16'h6, 16'hA006, 1'b1, 16'h7);
    cyc(1'b0, 16'h0, 16'h0,    1'b1, 16'h7);
    @(negedge clk);
    chk("t1_pre_count", 32'(count), 32'd3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb_if.ld_req = 1'b0;
    #1;
    chk("t1_async_count", 32'(count), 32'd0);
    chk("t1_async_empty", 32'(empty), 32'd1);
    chk("t1_async_we",    32'(sb_if.mem_write_en), 32'd0);
    chk("t1_async_ready", 32'(sb_if.st_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    @(negedge clk);
    chk("t1_dmem4", 32'(dmem[4]), 32'd0);
    chk("t1_dmem5", 32'(dmem[5]), 32'd0);
    chk("t1_dmem6", 32'(dmem[6]), 32'd0);

    // 2: single store drains the next cycle.
    cyc(1'b1, 16'h3, 16'h1234, 1'b0, 16'h0);
    idle(1);
    @(negedge clk);
    chk("t2_we",    32'(sb_if.mem_write_en), 32'd1);
    chk("t2_addr",  32'(sb_if.mem_access_addr), 32'h3);
    chk("t2_data",  32'(sb_if.mem_write_data), 32'h1234);
    chk("t2_count", 32'(count), 32'd1);
    idle(1);
    @(negedge clk);
    chk("t2_count0", 32'(count), 32'd0);
    chk("t2_dmem3",  32'(dmem[3]), 32'h1234);

    // 3: loads block the drain; buffer fills and refuses the 5th store.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 16'(16'h10 + (i < 4 ? i : 4)), 16'(16'hB000 + (i < 4 ? i : 4)), 1'b1, 16'h7);
      @(negedge clk);
      chk("t3_ready", 32'(sb_if.st_ready), 32'(i < 4));
      chk("t3_we",    32'(sb_if.mem_write_en), 32'd0);
    end
    idle(6);

    // 4: two stores to the same address; the younger one is forwarded.
    cyc(1'b1, 16'h2, 16'h1111, 1'b1, 16'h10);
    cyc(1'b1, 16'h2, 16'h2222, 1'b1, 16'h2);
    @(negedge clk);
    chk("t4_old_only", 32'(sb_if.ld_data), 32'h1111);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h2);
    @(negedge clk);
    chk("t4_fwd_a2",  32'(sb_if.ld_fwd), 32'd1);
    chk("t4_data_a2", 32'(sb_if.ld_data), 32'h2222);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'hA);
    @(negedge clk);
    chk("t4_fwd_aA",  32'(sb_if.ld_fwd), 32'd1);
    chk("t4_data_aA", 32'(sb_if.ld_data), 32'h2222);
    idle(3);

    // 5: same-cycle store and load see the old memory value.
    cyc(1'b1, 16'h5, 16'h00FF, 1'b0, 16'h0);
    idle(2);
    cyc(1'b1, 16'h5, 16'hABCD, 1'b1, 16'h5);
    @(negedge clk);
    chk("t5_same_data", 32'(sb_if.ld_data), 32'h00FF);
    chk("t5_same_fwd",  32'(sb_if.ld_fwd), 32'd0);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h5);
    @(negedge clk);
    chk("t5_next_data", 32'(sb_if.ld_data), 32'hABCD);
    chk("t5_next_fwd",  32'(sb_if.ld_fwd), 32'd1);
    idle(2);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h5);
    @(negedge clk);
    chk("t5_mem_data", 32'(sb_if.ld_data), 32'hABCD);
    chk("t5_mem_fwd",  32'(sb_if.ld_fwd), 32'd0);

    // 6: back-to-back stores with continuous drain wrap the pointers.
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cyc(1'b1, 16'(i * 3), 16'(16'hC000 + i), 1'b0, 16'h0);
      @(negedge clk);
      chk("t6_count_le1", 32'(count <= 3'd1), 32'd1);
    end
    idle(2);

    // Random mix against the scoreboard.
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom),
          1'($urandom_range(0, 3) == 0), 16'($urandom_range(0, 15)));

    cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("final_drained", 32'(sb_q.size()), 32'd0);
    chk("final_empty",   32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
